mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the two register read ports (rs/rt operand data) and holds the architectural HI/LO result registers.
- Runs MULT, MULTU, DIV and DIVU over multiple cycles with a start/busy/done handshake.
- Also supports direct HI/LO writes (MTHI/MTLO); HI/LO outputs feed the MFHI/MFLO writeback path.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count = WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  launch operation; sampled only when busy=0.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- rs_data  input  WIDTH  operand A (multiplicand/dividend), from reg_data1.
- rt_data  input  WIDTH  operand B (multiplier/divisor), from reg_data2.
- hi_write  input  1  MTHI: HI <= write_data.
- lo_write  input  1  MTLO: LO <= write_data.
- write_data  input  WIDTH  data for hi_write/lo_write.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; HI/LO are valid.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE.
- Reset mid-operation aborts immediately; no partial result reaches hi/lo.
- States and transitions:
  - IDLE: start=1 at edge E0 captures the operands and latches op. Signed ops store operand magnitudes plus result-sign flags. Go to MUL or DIV; busy=1 after E0.
  - MUL: radix-2 shift-add over a 2*WIDTH accumulator, one bit per edge, WIDTH edges (E1..E32). Then go to FIX.
  - DIV: restoring division, one quotient bit per edge, WIDTH edges. Then go to FIX.
  - FIX, at edge E33:
    - Apply sign correction: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
    - Write hi/lo: mult gives hi=product[63:32], lo=product[31:0]; div gives lo=quotient, hi=remainder.
    - Set done=1 and busy=0; return to IDLE.
- Latency: done is high in the cycle following E33, i.e. 33 edges after the start edge. done is high for exactly one cycle.
- Back-to-back: start may be asserted in the same cycle that done is high; it is accepted.
- start while busy=1: ignored, with no queuing.
- hi_write/lo_write while busy=1: ignored.
- hi_write/lo_write while idle: the register updates on the next edge. If start is asserted in the same idle cycle, the move still happens; the operation result overwrites it at completion.
- Both hi_write and lo_write asserted: both registers take write_data.
- Divide by zero (DIV or DIVU, rt_data=0): lo=32'hFFFFFFFF, hi=rs_data, with no sign correction. Same latency; the result is decided at E0 and the iteration still runs WIDTH cycles.
- DIV overflow (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0.
- Signed magnitude of 0x80000000 is 0x80000000, treated as unsigned; this requires no special-casing.
- hi/lo hold their value between operations; they change only on FIX, a move, or reset.

Decomposition:
- Shared package cpu_pkg: op encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU), state encoding, WIDTH default.
- One natural sub-module: mdu_sign_fix. It is combinational: takes magnitude results plus sign flags and returns corrected hi/lo values.
- The control FSM and iterative datapath stay in mult_div_unit.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done 33 edges after start; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- MULT 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then DIVU 100/0 -> lo=0xFFFFFFFF, hi=100.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. Then a back-to-back start in the done cycle is accepted, with busy=1 on the next cycle.
- Idle hi_write with write_data=0x12345678 -> hi=0x12345678 next cycle. hi_write or a second start during busy -> no effect; the result matches the first operation.
- Assert rst asynchronously at E10 of a MULT -> busy=0, hi=lo=0 immediately. No done pulse follows; a new start after reset completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the execute-stage multiply/divide unit.
package cpu_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } mdu_state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Combinational sign correction: turns magnitude product/quotient/remainder
// into final signed HI/LO values.
module mdu_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               is_div,
  input  logic               neg_res,
  input  logic               neg_rem,
  input  logic [2*WIDTH-1:0] mag,
  output logic [WIDTH-1:0]   hi_out,
  output logic [WIDTH-1:0]   lo_out
);

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  always_comb begin
    prod = neg_res ? -mag : mag;
    quo  = neg_res ? -mag[WIDTH-1:0] : mag[WIDTH-1:0];
    rem  = neg_rem ? -mag[2*WIDTH-1:WIDTH] : mag[2*WIDTH-1:WIDTH];
    if (is_div) begin
      hi_out = rem;
      lo_out = quo;
    end else begin
      hi_out = prod[2*WIDTH-1:WIDTH];
      lo_out = prod[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One result bit per cycle; sign correction applied in a final FIX cycle.
module mult_div_unit
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_write,
  input  logic             lo_write,
  input  logic [WIDTH-1:0] write_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  mdu_state_e         state_q, state_d;
  mdu_op_e            op_e;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic               is_div_q, neg_res_q, neg_rem_q;
  logic [WIDTH-1:0]   hi_q, lo_q, fix_hi, fix_lo;
  logic               done_q;

  logic               signed_op, is_div_op, a_neg, b_neg, div_zero;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next;

  always_comb begin
    op_e      = mdu_op_e'(op);
    signed_op = (op_e == MDU_MULT) || (op_e == MDU_DIV);
    is_div_op = (op_e == MDU_DIV) || (op_e == MDU_DIVU);
    div_zero  = is_div_op && (rt_data == '0);
    a_neg     = signed_op && rs_data[WIDTH-1];
    b_neg     = signed_op && rt_data[WIDTH-1];
    // Divide-by-zero runs the raw dividend unsigned with no sign flags; the
    // restoring loop then yields quotient all-ones and remainder = rs_data.
    a_mag     = (a_neg && !div_zero) ? -rs_data : rs_data;
    b_mag     = b_neg ? -rt_data : rt_data;
  end

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    if (div_trial[WIDTH])
      div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    else
      div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = is_div_op ? ST_DIV : ST_MUL;
      ST_MUL,
      ST_DIV:  if (cnt_q == CW'(WIDTH - 1)) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          cnt_q     <= '0;
          is_div_q  <= is_div_op;
          neg_res_q <= !div_zero && (a_neg ^ b_neg);
          neg_rem_q <= !div_zero && is_div_op && a_neg;
          // Mult: multiplier in low half, multiplicand held aside.
          // Div: dividend in low half, divisor held aside.
          acc_q     <= {{WIDTH{1'b0}}, is_div_op ? a_mag : b_mag};
          opnd_q    <= is_div_op ? b_mag : a_mag;
        end
        ST_MUL: begin
          acc_q <= mul_next;
          cnt_q <= cnt_q + CW'(1);
        end
        ST_DIV: begin
          acc_q <= div_next;
          cnt_q <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .is_div  (is_div_q),
    .neg_res (neg_res_q),
    .neg_rem (neg_rem_q),
    .mag     (acc_q),
    .hi_out  (fix_hi),
    .lo_out  (fix_lo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == ST_FIX);
      if (state_q == ST_FIX) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end else if (state_q == ST_IDLE) begin
        if (hi_write) hi_q <= write_data;
        if (lo_write) lo_q <= write_data;
      end
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;

  logic        clk, rst, start, hi_write, lo_write;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data, write_data;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .hi_write   (hi_write),
    .lo_write   (lo_write),
    .write_data (write_data),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges until done is seen (bounded); also counts cycles with busy=1.
  task automatic wait_done(output int n, output int bcnt);
    n = 0;
    bcnt = busy ? 1 : 0;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (busy) bcnt++;
      if (done) break;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
    hi_write = 1'b0; lo_write = 1'b0; write_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL reset_hilo hi=%h lo=%h expected 0/0", hi, lo); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_ctl busy=%b done=%b expected 0/0", busy, done); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_multu;
    int n, b;
    launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL multu_busy_after_e0 got=%b expected 1", busy); end
    wait_done(n, b);
    checks++; if (n !== 33) begin errors++; $display("FAIL multu_latency edges=%0d expected 33", n); end
    checks++; if (b !== 33) begin errors++; $display("FAIL multu_busy_cycles got=%0d expected 33", b); end
    checks++; if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin errors++; $display("FAIL multu_result hi=%h lo=%h expected fffffffe/00000001", hi, lo); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse done=%b expected 0", done); end
  endtask

  task automatic test_mult;
    int n, b;
    launch(2'b00, 32'hFFFFFFFD, 32'd7);
    wait_done(n, b);
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_neg hi=%h lo=%h expected ffffffff/ffffffeb", hi, lo); end
  endtask

  task automatic test_div;
    int n, b;
    launch(2'b10, 32'hFFFFFFF9, 32'd2);
    wait_done(n, b);
    checks++; if (n !== 33) begin errors++; $display("FAIL div_latency edges=%0d expected 33", n); end
    checks++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_signed hi=%h lo=%h expected ffffffff/fffffffd", hi, lo); end
    launch(2'b11, 32'd100, 32'd0);
    wait_done(n, b);
    checks++; if (n !== 33) begin errors++; $display("FAIL divu_zero_latency edges=%0d expected 33", n); end
    checks++; if (lo !== 32'hFFFFFFFF || hi !== 32'd100) begin errors++; $display("FAIL divu_zero hi=%h lo=%h expected 00000064/ffffffff", hi, lo); end
    launch(2'b10, 32'hFFFFFFF9, 32'd0);
    wait_done(n, b);
    checks++; if (lo !== 32'hFFFFFFFF || hi !== 32'hFFFFFFF9) begin errors++; $display("FAIL div_zero_signed hi=%h lo=%h expected fffffff9/ffffffff", hi, lo); end
  endtask

  task automatic test_back_to_back;
    int n, b;
    launch(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_done(n, b);
    checks++; if (lo !== 32'h80000000 || hi !== 32'h0) begin errors++; $display("FAIL div_overflow hi=%h lo=%h expected 00000000/80000000", hi, lo); end
    launch(2'b01, 32'd6, 32'd7);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept busy=%b expected 1", busy); end
    wait_done(n, b);
    checks++; if (n !== 33) begin errors++; $display("FAIL b2b_latency edges=%0d expected 33", n); end
    checks++; if (hi !== 32'h0 || lo !== 32'd42) begin errors++; $display("FAIL b2b_result hi=%h lo=%h expected 00000000/0000002a", hi, lo); end
  endtask

  task automatic test_moves;
    int n, b;
    @(negedge clk); hi_write = 1'b1; write_data = 32'h12345678;
    @(posedge clk); #1; hi_write = 1'b0;
    checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL mthi hi=%h expected 12345678", hi); end
    @(negedge clk); hi_write = 1'b1; lo_write = 1'b1; write_data = 32'hCAFEF00D;
    @(posedge clk); #1; hi_write = 1'b0; lo_write = 1'b0;
    checks++; if (hi !== 32'hCAFEF00D || lo !== 32'hCAFEF00D) begin errors++; $display("FAIL mthi_mtlo hi=%h lo=%h expected cafef00d/cafef00d", hi, lo); end
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs_data = 32'd9; rt_data = 32'd9;
    lo_write = 1'b1; write_data = 32'h00000055;
    @(posedge clk); #1; start = 1'b0; lo_write = 1'b0;
    checks++; if (lo !== 32'h00000055 || busy !== 1'b1) begin errors++; $display("FAIL move_with_start lo=%h busy=%b expected 00000055/1", lo, busy); end
    wait_done(n, b);
    checks++; if (hi !== 32'h0 || lo !== 32'd81) begin errors++; $display("FAIL move_overwritten hi=%h lo=%h expected 00000000/00000051", hi, lo); end
  endtask

  task automatic test_busy_ignore;
    int n, b;
    @(negedge clk); hi_write = 1'b1; lo_write = 1'b1; write_data = 32'h0BADF00D;
    @(posedge clk); #1; hi_write = 1'b0; lo_write = 1'b0;
    launch(2'b01, 32'd3, 32'd5);
    @(negedge clk);
    hi_write = 1'b1; write_data = 32'hDEADBEEF;
    start = 1'b1; op = 2'b11; rs_data = 32'd100; rt_data = 32'd7;
    @(posedge clk); #1; hi_write = 1'b0; start = 1'b0;
    checks++; if (hi !== 32'h0BADF00D) begin errors++; $display("FAIL busy_mthi hi=%h expected 0badf00d", hi); end
    wait_done(n, b);
    checks++; if (n !== 32) begin errors++; $display("FAIL busy_start_latency edges=%0d expected 32", n); end
    checks++; if (hi !== 32'h0 || lo !== 32'd15) begin errors++; $display("FAIL busy_start_result hi=%h lo=%h expected 00000000/0000000f", hi, lo); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_no_queue busy=%b expected 0", busy); end
  endtask

  task automatic test_async_reset;
    int n, b, seen;
    @(negedge clk); hi_write = 1'b1; lo_write = 1'b1; write_data = 32'hAAAA5555;
    @(posedge clk); #1; hi_write = 1'b0; lo_write = 1'b0;
    launch(2'b00, 32'hFFFFFFFD, 32'd7);
    repeat (10) @(posedge clk);
    #2; rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL async_reset busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo); end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL reset_abort done_or_busy_cycles=%0d expected 0", seen); end
    launch(2'b01, 32'h00010000, 32'h00010000);
    wait_done(n, b);
    checks++; if (n !== 33 || hi !== 32'h1 || lo !== 32'h0) begin errors++; $display("FAIL post_reset_op edges=%0d hi=%h lo=%h expected 33/00000001/00000000", n, hi, lo); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_back_to_back();
    test_moves();
    test_busy_ignore();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
